axi_reg_master: RTL
===================

# axi_reg_master

- Host-side initiator for the motor controller's simplified AXI register port.
- Accepts single read/write commands on a valid/ready command port and runs the matching address, data and response handshakes against the register slave.
- Returns read data or write completion on a one-cycle response strobe.
- Used by the on-chip supervisor and the system bench to program PWM registers and poll the speed register.

## Interface

- DATA_WIDTH, 32, register width.
- ADDR_WIDTH, 2, register address width.
- TIMEOUT_CYCLES, 64, cycles allowed in any wait state before abort; must be ≥ 2.

Ports, clock and reset first:

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master idle; command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target register.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  qualified by rsp_valid; 1 = timeout.
- awvalid  out  1  write address valid.
- awready  in  1  slave accepts address.
- awaddr  out  ADDR_WIDTH  write address.
- wdata  out  DATA_WIDTH  write data.
- wvalid  out  1  write data valid.
- wready  in  1  slave accepts data.
- wresp  in  1  one-cycle write-complete pulse from slave.
- arvalid  out  1  read address valid.
- arready  in  1  slave accepts read address.
- araddr  out  ADDR_WIDTH  read address.
- rData  in  DATA_WIDTH  read data.
- rvalid  in  1  rData valid (one-cycle pulse).

## Operation

- States:
  - IDLE: cmd_ready = 1. On accept, latch cmd_addr and cmd_wdata into awaddr/araddr and wdata, then go to WR_REQ if cmd_write, else RD_REQ.
  - WR_REQ: awvalid and wvalid raised together. Each drops independently the cycle after its ready is sampled high. Once both handshakes are done, go to WR_RESP. A handshake completing in the same cycle as the other counts as done.
  - WR_RESP: wait for wresp, then go to DONE.
    - wresp in the same cycle as the final aw/w handshake is accepted as completion; go directly to DONE.
  - RD_REQ: arvalid held until arready is sampled high, then go to RD_RESP. rvalid in the same cycle as arready is accepted; capture rData and go to DONE.
  - RD_RESP: on rvalid, capture rData and go to DONE.
  - DONE: rsp_valid = 1 for one cycle, then return to IDLE.
- One outstanding transaction only. No bready/rready exist; the master always accepts wresp and rvalid.
- Timeout:
  - A counter clears on entry to WR_REQ and RD_REQ, keeps counting through the following response state, and saturates.
  - When the count reaches TIMEOUT_CYCLES, drop all valids, go to DONE with rsp_err = 1 and rsp_rdata = 0.
- wresp or rvalid arriving in IDLE or DONE is ignored.
- Address and data outputs hold their last value while the corresponding valid is low.

## Timing

- Reset (rst low): all outputs 0, including cmd_ready; state IDLE. cmd_ready rises on the first clk edge after rst deasserts.
- Command accepted at edge N: cmd_ready = 0 and awvalid/wvalid (or arvalid) = 1 from edge N.
- Zero-wait slave (ready high immediately, response the following cycle):
  - Write: rsp_valid at edge N+3.
  - Read: rsp_valid at edge N+3.
- cmd_ready returns high the cycle after rsp_valid. Minimum back-to-back command spacing is 4 cycles.
- rst asserted mid-transaction: all valids drop immediately and asynchronously. No response is issued for the aborted command.

## Structure

- Shared package motor_axi_pkg holds:
  - the master state enum;
  - the register address constants: ADDR_SPEED = 0, ADDR_PWM_PERIOD = 1, ADDR_PWM_DUTY = 2;
  - TIMEOUT default.
- The timeout counter is the one natural sub-module: axi_timeout_ctr (clear, enable, expired).
- Everything else is one FSM module.

## Test plan

- Write 0x0000_03E8 to addr 1 with a zero-wait slave -> one aw and one w handshake, awaddr = 1, wdata = 0x3E8, rsp_valid at N+3, rsp_err = 0.
- awready delayed 5 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 5 cycles, single rsp_valid after wresp, rsp_err = 0.
- Read addr 0 with slave returning rData = 0x0000_0BB8 two cycles after arready -> rsp_rdata = 0xBB8, rsp_err = 0.
- Slave never asserts arready (TIMEOUT_CYCLES = 64) -> arvalid drops after 64 cycles, rsp_valid with rsp_err = 1 and rsp_rdata = 0, cmd_ready high the next cycle.
- Spurious wresp/rvalid while IDLE, then rst pulsed low mid-write -> no rsp_valid for either; all outputs 0 during reset; next command completes normally.

Source files
------------

// File: rtl/motor_axi_pkg.sv
// Shared definitions for the motor controller's simplified AXI register port.
package motor_axi_pkg;

    // Register master sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_DONE
    } mst_state_t;

    // Register map of the motor controller slave
    localparam logic [1:0] ADDR_SPEED      = 2'd0;
    localparam logic [1:0] ADDR_PWM_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_PWM_DUTY   = 2'd2;

    // Default number of wait cycles before a transaction is abandoned
    localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/axi_timeout_ctr.sv
// Saturating wait-cycle counter; flags the cycle on which the wait budget runs out.
module axi_timeout_ctr
    import motor_axi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SAT   = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    // Count enabled wait cycles, holding at the saturation value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != SAT)) begin
            count <= count + 1'b1;
        end
    end

    // Expiry fires on the TIMEOUT_CYCLES-th enabled cycle so the FSM leaves on that edge
    assign expired = enable && (count >= LIMIT);

endmodule

// File: rtl/axi_reg_master.sv
// Single-outstanding register initiator: command port in, AW/W/B-pulse or AR/R-pulse out.
module axi_reg_master
    import motor_axi_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  wresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    input  logic [DATA_WIDTH-1:0] rData,
    input  logic                  rvalid
);

    mst_state_t            state_q, state_d;
    logic                  rdy_en_q;
    logic                  aw_done_q, w_done_q, err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                  accept, rd_capture, tmo_hit, aw_ok, w_ok;
    logic                  wait_st, expired;

    assign wait_st = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                     (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);

    axi_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (wait_st),
        .expired(expired)
    );

    // State register; reset forces IDLE so every valid drops asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; a completing handshake wins over a coincident timeout
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        rd_capture = 1'b0;
        tmo_hit    = 1'b0;
        aw_ok      = aw_done_q || awready;
        w_ok       = w_done_q || wready;
        cmd_ready  = rdy_en_q && (state_q == ST_IDLE);
        awvalid    = (state_q == ST_WR_REQ) && !aw_done_q;
        wvalid     = (state_q == ST_WR_REQ) && !w_done_q;
        arvalid    = (state_q == ST_RD_REQ);
        rsp_valid  = (state_q == ST_DONE);
        rsp_err    = (state_q == ST_DONE) && err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (aw_ok && w_ok) begin
                    state_d = wresp ? ST_DONE : ST_WR_RESP;
                end else if (expired) begin
                    tmo_hit = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WR_RESP: begin
                if (wresp) begin
                    state_d = ST_DONE;
                end else if (expired) begin
                    tmo_hit = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD_REQ: begin
                if (arready) begin
                    rd_capture = rvalid;
                    state_d    = rvalid ? ST_DONE : ST_RD_RESP;
                end else if (expired) begin
                    tmo_hit = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD_RESP: begin
                if (rvalid) begin
                    rd_capture = 1'b1;
                    state_d    = ST_DONE;
                end else if (expired) begin
                    tmo_hit = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Transaction context: latched command, per-channel handshake flags and response data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (accept) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                err_q     <= 1'b0;
                rdata_q   <= '0;
            end
            if (state_q == ST_WR_REQ) begin
                if (awready) aw_done_q <= 1'b1;
                if (wready)  w_done_q  <= 1'b1;
            end
            if (rd_capture) rdata_q <= rData;
            if (tmo_hit) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign rsp_rdata = rdata_q;

endmodule
